// File: rtl/serial_frame_loader.sv
// serial_frame_loader: byte-stream front end for a 48-bit LSB-first serial shifter.
// Buffers producer bytes in a small FIFO, groups them into frames of 1..MAX_BYTES
// bytes, strobes each byte into the shifter (ser_get), then starts the shift
// (ser_send) and holds off for 8N+1 cycles while the shifter drains.
// Ports:
//   clk, nRst          clock, asynchronous active-low reset
//   in_data/in_valid/in_last/in_ready   producer byte stream (valid/ready)
//   ser_data/ser_sel   byte and its index within the frame, valid with ser_get
//   ser_get            one-cycle byte-load strobe
//   ser_send           one-cycle start-shift strobe
//   busy               high whenever the sequencer is not idle
//   frames_sent        count of ser_send pulses (wraps)
module serial_frame_loader #(
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned MAX_BYTES = 6
) (
  input  logic       clk,
  input  logic       nRst,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  input  logic       in_last,
  output logic       in_ready,
  output logic [7:0] ser_data,
  output logic [2:0] ser_sel,
  output logic       ser_get,
  output logic       ser_send,
  output logic       busy,
  output logic [7:0] frames_sent
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam int unsigned DW = 9;
  localparam int unsigned NW = 3;
  localparam int unsigned WW = 6;

  typedef enum logic [1:0] {IDLE, LOAD, SEND, WAIT} state_t;

  // FIFO storage and pointers (extra MSB distinguishes full from empty)
  logic [DW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr, wr_ptr_n, rd_ptr_n;
  logic          empty, full_n, push, pop;
  logic [DW-1:0] head;

  assign push     = in_valid && in_ready;
  assign empty    = (wr_ptr == rd_ptr);
  assign head     = mem[rd_ptr[AW-1:0]];
  assign wr_ptr_n = wr_ptr + PW'(push);
  assign rd_ptr_n = rd_ptr + PW'(pop);
  assign full_n   = (wr_ptr_n[AW] != rd_ptr_n[AW]) &&
                    (wr_ptr_n[AW-1:0] == rd_ptr_n[AW-1:0]);

  // FIFO data write
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= {in_last, in_data};
  end

  // FIFO pointers; in_ready tracks the post-update fill level
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      in_ready <= 1'b1;
    end else begin
      wr_ptr   <= wr_ptr_n;
      rd_ptr   <= rd_ptr_n;
      in_ready <= !full_n;
    end
  end

  // Sequencer state
  state_t        state, state_n;
  logic [NW-1:0] n, n_n, nb, nb_n;
  logic [WW-1:0] w, w_n;
  logic [7:0]    data_n, cnt_n;
  logic [2:0]    sel_n;
  logic          get_n, send_n;

  // Next-state and registered-output values
  always_comb begin
    state_n = state;
    pop     = 1'b0;
    n_n     = n;
    nb_n    = nb;
    w_n     = w;
    get_n   = 1'b0;
    send_n  = 1'b0;
    data_n  = ser_data;
    sel_n   = ser_sel;
    cnt_n   = frames_sent;
    unique case (state)
      IDLE: begin
        n_n = '0;
        if (!empty) state_n = LOAD;
      end
      LOAD: begin
        if (!empty) begin
          pop    = 1'b1;
          get_n  = 1'b1;
          data_n = head[7:0];
          sel_n  = n;
          n_n    = n + NW'(1);
          // Close on the producer's marker or when the shifter is full
          if (head[8] || ((32'(n) + 32'd1) == MAX_BYTES)) begin
            nb_n    = n + NW'(1);
            state_n = SEND;
          end
        end
      end
      SEND: begin
        send_n  = 1'b1;
        cnt_n   = frames_sent + 8'd1;
        w_n     = {nb, 3'b000};
        state_n = WAIT;
      end
      WAIT: begin
        if (w == '0) state_n = IDLE;
        else         w_n     = w - WW'(1);
      end
      default: state_n = IDLE;
    endcase
  end

  // Sequencer registers
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state       <= IDLE;
      n           <= '0;
      nb          <= '0;
      w           <= '0;
      ser_get     <= 1'b0;
      ser_send    <= 1'b0;
      ser_data    <= '0;
      ser_sel     <= '0;
      busy        <= 1'b0;
      frames_sent <= '0;
    end else begin
      state       <= state_n;
      n           <= n_n;
      nb          <= nb_n;
      w           <= w_n;
      ser_get     <= get_n;
      ser_send    <= send_n;
      ser_data    <= data_n;
      ser_sel     <= sel_n;
      busy        <= (state_n != IDLE);
      frames_sent <= cnt_n;
    end
  end

endmodule

// File: tb/tb_serial_frame_loader.sv
// Directed self-checking bench for serial_frame_loader.
module tb_serial_frame_loader;

  logic       clk = 1'b0;
  logic       nRst;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_last;
  logic       in_ready;
  logic [7:0] ser_data;
  logic [2:0] ser_sel;
  logic       ser_get;
  logic       ser_send;
  logic       busy;
  logic [7:0] frames_sent;

  serial_frame_loader #(.DEPTH(8), .MAX_BYTES(6)) dut (
    .clk(clk), .nRst(nRst),
    .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
    .ser_data(ser_data), .ser_sel(ser_sel), .ser_get(ser_get), .ser_send(ser_send),
    .busy(busy), .frames_sent(frames_sent)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] d;
    logic [2:0] s;
    int         c;
  } get_t;

  get_t get_q[$];
  int   send_q[$];
  int   cyc = 0;
  int   n_assert = 0;
  int   n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every strobe seen by the shifter
  always @(negedge clk) begin
    if (ser_get === 1'b1)  get_q.push_back('{ser_data, ser_sel, cyc});
    if (ser_send === 1'b1) send_q.push_back(cyc);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_rng(input string tag, input int obs, input int lo, input int hi);
    n_assert++;
    assert (obs >= lo && obs <= hi) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
    end
  endtask

  task automatic push(input logic [7:0] d, input logic l);
    int b;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    b = 0;
    while (in_ready !== 1'b1 && b < 500) begin
      @(negedge clk);
      b++;
    end
    if (in_ready !== 1'b1) begin
      chk("push_ready_timeout", 64'(in_ready), 64'd1);
      in_valid = 1'b0;
    end else begin
      @(posedge clk);
    end
  endtask

  task automatic drop();
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_sends(input int n, input int budget);
    int b;
    b = 0;
    while (send_q.size() < n && b < budget) begin
      @(negedge clk);
      b++;
    end
    if (send_q.size() < n) chk("send_timeout", 64'(send_q.size()), 64'(n));
  endtask

  task automatic wait_idle(input int budget);
    int b;
    b = 0;
    while (busy !== 1'b0 && b < budget) begin
      @(negedge clk);
      b++;
    end
    if (busy !== 1'b0) chk("idle_timeout", 64'(busy), 64'd0);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    chk({tag, "_ser_data"}, 64'(ser_data), 64'd0);
    chk({tag, "_ser_sel"},  64'(ser_sel),  64'd0);
    chk({tag, "_ser_get"},  64'(ser_get),  64'd0);
    chk({tag, "_ser_send"}, 64'(ser_send), 64'd0);
    chk({tag, "_busy"},     64'(busy),     64'd0);
    chk({tag, "_frames"},   64'(frames_sent), 64'd0);
  endtask

  initial begin
    logic [47:0] tx;
    logic        prev_rdy;
    int          b;
    int          gb;
    int          sb;

    nRst = 1'b0; in_valid = 1'b0; in_data = 8'h00; in_last = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset("rst");
    nRst = 1'b1;

    // Single-byte frame
    push(8'hA5, 1'b1); drop();
    wait_sends(1, 100);
    chk("f1_gets", 64'(get_q.size()), 64'd1);
    chk("f1_data", 64'(get_q[0].d), 64'hA5);
    chk("f1_sel",  64'(get_q[0].s), 64'd0);
    chk("f1_send_lat", 64'(send_q[0]), 64'(get_q[0].c + 1));
    chk("f1_frames", 64'(frames_sent), 64'd1);

    // Full six-byte frame, pushed while frame 1 drains
    for (int i = 1; i <= 6; i++) push(8'(i), (i == 6));
    drop();
    wait_sends(2, 200);
    chk_rng("f2_gap_after_n1", get_q[1].c - send_q[0], 10, 11);
    tx = '0;
    for (int i = 0; i < 6; i++) begin
      chk("f2_data", 64'(get_q[1+i].d), 64'(i + 1));
      chk("f2_sel",  64'(get_q[1+i].s), 64'(i));
      chk("f2_back_to_back", 64'(get_q[1+i].c), 64'(get_q[1].c + i));
      tx[8*i +: 8] = get_q[1+i].d;
    end
    chk("f2_tx_bits", 64'(tx), 64'h0000_0605_0403_0201);
    chk("f2_send_lat", 64'(send_q[1]), 64'(get_q[6].c + 1));
    chk("f2_frames", 64'(frames_sent), 64'd2);

    // Eight bytes without a marker fill the FIFO during the 49-cycle wait
    for (int i = 0; i < 8; i++) push(8'h31 + 8'(i), 1'b0);
    drop();
    chk("full_ready_low", 64'(in_ready), 64'd0);
    chk("full_busy", 64'(busy), 64'd1);
    prev_rdy = in_ready;
    b = 0;
    while (ser_get !== 1'b1 && b < 200) begin
      prev_rdy = in_ready;
      @(negedge clk);
      b++;
    end
    chk("ready_low_before_pop", 64'(prev_rdy), 64'd0);
    chk("ready_after_first_pop", 64'(in_ready), 64'd1);
    wait_sends(3, 200);
    chk_rng("f3_gap_after_n6", get_q[7].c - send_q[1], 50, 51);
    for (int i = 0; i < 6; i++) begin
      chk("f3_data", 64'(get_q[7+i].d), 64'(8'h31 + 8'(i)));
      chk("f3_sel",  64'(get_q[7+i].s), 64'(i));
    end
    chk("f3_forced_close", 64'(send_q[2]), 64'(get_q[12].c + 1));
    repeat (80) @(negedge clk);
    chk("f4_no_send_yet", 64'(send_q.size()), 64'd3);
    chk("f4_held_gets", 64'(get_q.size()), 64'd15);
    chk("f4_held_busy", 64'(busy), 64'd1);
    chk_rng("f4_gap_after_n6", get_q[13].c - send_q[2], 50, 51);
    chk("f4_b0", 64'({get_q[13].d, get_q[13].s}), 64'({8'h37, 3'd0}));
    chk("f4_b1", 64'({get_q[14].d, get_q[14].s}), 64'({8'h38, 3'd1}));
    push(8'h39, 1'b1); drop();
    wait_sends(4, 100);
    chk("f4_b2", 64'({get_q[15].d, get_q[15].s}), 64'({8'h39, 3'd2}));
    chk("f4_send_lat", 64'(send_q[3]), 64'(get_q[15].c + 1));
    chk("f4_frames", 64'(frames_sent), 64'd4);

    // Producer gap inside a frame stalls the loader
    wait_idle(100);
    push(8'h11, 1'b0); drop();
    repeat (5) @(negedge clk);
    push(8'h22, 1'b1); drop();
    wait_sends(5, 100);
    chk("f5_b0", 64'({get_q[16].d, get_q[16].s}), 64'({8'h11, 3'd0}));
    chk("f5_b1", 64'({get_q[17].d, get_q[17].s}), 64'({8'h22, 3'd1}));
    chk_rng("f5_stall", get_q[17].c - get_q[16].c, 6, 20);
    chk("f5_send_lat", 64'(send_q[4]), 64'(get_q[17].c + 1));
    push(8'h77, 1'b1); drop();
    wait_sends(6, 100);
    chk_rng("f6_gap_after_n2", get_q[18].c - send_q[4], 18, 19);
    chk("f6_b0", 64'({get_q[18].d, get_q[18].s}), 64'({8'h77, 3'd0}));
    chk("f6_frames", 64'(frames_sent), 64'd6);

    // Reset in the middle of WAIT
    repeat (3) @(negedge clk);
    chk("pre_rst_busy", 64'(busy), 64'd1);
    nRst = 1'b0;
    #1;
    chk_reset("midrst");
    repeat (2) @(negedge clk);
    nRst = 1'b1;
    gb = get_q.size();
    sb = send_q.size();
    push(8'h81, 1'b0);
    push(8'h82, 1'b1);
    drop();
    wait_sends(sb + 1, 100);
    chk("post_rst_gets", 64'(get_q.size()), 64'(gb + 2));
    chk("post_rst_b0", 64'({get_q[gb].d, get_q[gb].s}), 64'({8'h81, 3'd0}));
    chk("post_rst_b1", 64'({get_q[gb+1].d, get_q[gb+1].s}), 64'({8'h82, 3'd1}));
    chk("post_rst_frames", 64'(frames_sent), 64'd1);

    // 255 more single-byte frames wrap the counter to zero
    for (int i = 0; i < 255; i++) push(8'(i), 1'b1);
    drop();
    wait_sends(sb + 256, 8000);
    repeat (2) @(negedge clk);
    chk("wrap_frames", 64'(frames_sent), 64'd0);
    chk("wrap_gets", 64'(get_q.size()), 64'(gb + 257));
    chk("wrap_last", 64'({get_q[gb+256].d, get_q[gb+256].s}), 64'({8'hFE, 3'd0}));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
